mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single fixed-latency synchronous memory port.
// Data has priority; fetch is forced through after MAX_D consecutive data wins while it waits.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned MAX_D   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic        stall_if,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] STARVE_MAX = 2'(MAX_D);
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);

    logic [1:0] state;
    logic [1:0] starve_cnt;
    logic [2:0] lat_cnt;
    logic       win_fetch;
    logic       any_req;
    logic       fetch_wins;

    assign any_req    = if_req | d_req;
    assign fetch_wins = if_req & (~d_req | (starve_cnt == STARVE_MAX));

    // Fetch stops stalling only in the cycle its grant is presented.
    assign stall_if = if_req & ~((state == ISSUE) & win_fetch);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 2'd0;
            lat_cnt    <= 3'd0;
            win_fetch  <= 1'b0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            busy       <= 1'b0;
            m_addr     <= 16'h0000;
            m_wdata    <= 16'h0000;
            if_rdata   <= 16'h0000;
            d_rdata    <= 16'h0000;
        end else begin
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            m_en     <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        m_en      <= 1'b1;
                        lat_cnt   <= LAT_LOAD;
                        win_fetch <= fetch_wins;
                        if (fetch_wins) begin
                            if_gnt     <= 1'b1;
                            m_addr     <= if_addr;
                            m_we       <= 1'b0;
                            starve_cnt <= 2'd0;
                        end else begin
                            d_gnt  <= 1'b1;
                            m_addr <= d_addr;
                            m_we   <= d_we;
                            if (d_we) begin
                                m_wdata <= d_wdata;
                            end
                            if (!if_req) begin
                                starve_cnt <= 2'd0;
                            end else if (starve_cnt != STARVE_MAX) begin
                                starve_cnt <= starve_cnt + 2'd1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state <= DONE;
                        if (win_fetch) begin
                            if_valid <= 1'b1;
                            if_rdata <= m_rdata;
                        end else begin
                            d_valid <= 1'b1;
                            // A store completes without touching the load data register.
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    m_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
